// File: rtl/digger_keys_pkg.sv
// Shared scancode constants, key identifiers and prefix-FSM state type for
// the PS/2 keyboard front end of the player block.
//   SC_*         PS/2 set-2 scancodes of interest
//   KEY_*        index of each tracked key in the raw/latched key vectors
//   kbd_state_t  prefix tracking state (E0 / F0 / E0 F0)
//   arrowId()    maps an extended arrow code to its key index, KEY_NONE otherwise
package digger_keys_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam int unsigned NUM_KEYS = 5;
  localparam logic [2:0] KEY_LEFT  = 3'd0;
  localparam logic [2:0] KEY_RIGHT = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_UP    = 3'd3;
  localparam logic [2:0] KEY_FIRE  = 3'd4;
  localparam logic [2:0] KEY_NONE  = 3'd7;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kbd_state_t;

  function automatic logic [2:0] arrowId(input logic [7:0] code);
    case (code)
      SC_LEFT:  arrowId = KEY_LEFT;
      SC_RIGHT: arrowId = KEY_RIGHT;
      SC_DOWN:  arrowId = KEY_DOWN;
      SC_UP:    arrowId = KEY_UP;
      default:  arrowId = KEY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/scan_prefix_fsm.sv
// Scancode prefix tracker. Follows E0 (extended) and F0 (break) prefixes and
// reports each completed key event for one clock. A prefix state left without
// a following byte for TIMEOUT_CYCLES clocks falls back to IDLE.
//   clk, resetN     system clock, synchronous active-low reset
//   din, din_new    scancode byte and its 1-cycle valid strobe
//   key_id          key index of the event (KEY_NONE when no event)
//   key_make        1-cycle strobe: key_id pressed
//   key_brk_strobe  1-cycle strobe: key_id released
module scan_prefix_fsm
  import digger_keys_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       din_new,
  output logic [2:0] key_id,
  output logic       key_make,
  output logic       key_brk_strobe
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  kbd_state_t       state, nextState;
  logic [CNT_W-1:0] toCnt;
  logic             timedOut;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      toCnt <= '0;
    end else begin
      state <= nextState;
      // Saturates at CNT_LAST; the forced return to IDLE clears it next clock.
      if (state == IDLE || din_new)
        toCnt <= '0;
      else if (toCnt != CNT_LAST)
        toCnt <= toCnt + CNT_W'(1);
    end
  end

  assign timedOut = (state != IDLE) && (toCnt == CNT_LAST);

  always_comb begin
    nextState      = state;
    key_id         = KEY_NONE;
    key_make       = 1'b0;
    key_brk_strobe = 1'b0;
    // A byte arriving on the expiry clock is still decoded in its prefix state.
    if (din_new) begin
      case (state)
        IDLE: begin
          if (din == SC_EXT)
            nextState = EXT;
          else if (din == SC_BRK)
            nextState = BRK;
          else if (din == SC_SPACE) begin
            key_id   = KEY_FIRE;
            key_make = 1'b1;
          end
        end
        EXT: begin
          if (din == SC_BRK)
            nextState = EXT_BRK;
          else if (din != SC_EXT) begin
            nextState = IDLE;
            key_id    = arrowId(din);
            key_make  = (key_id != KEY_NONE);
          end
        end
        BRK: begin
          nextState = IDLE;
          if (din == SC_SPACE) begin
            key_id         = KEY_FIRE;
            key_brk_strobe = 1'b1;
          end
        end
        EXT_BRK: begin
          nextState      = IDLE;
          key_id         = arrowId(din);
          key_brk_strobe = (key_id != KEY_NONE);
        end
        default: nextState = IDLE;
      endcase
    end else if (timedOut) begin
      nextState = IDLE;
    end
  end

endmodule

// File: rtl/arrow_key_decoder.sv
// PS/2 byte stream to held-key levels for the player block. Raw key bits follow
// make/break events immediately; the outputs are a copy of the raw bits taken
// at each startOfFrame, so they are stable for a whole frame.
//   clk, resetN          system clock, synchronous active-low reset
//   startOfFrame         1-cycle strobe at the start of each video frame
//   din, din_new         scancode byte and its 1-cycle valid strobe
//   left/right/down/upArrowPressed  frame-latched arrow levels
//   firePressed          frame-latched space-bar level
//   firePulse            1 clk high at the frame where firePressed goes 0->1
module arrow_key_decoder
  import digger_keys_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [7:0] din,
  input  logic       din_new,
  output logic       leftArrowPressed,
  output logic       rightArrowPressed,
  output logic       downArrowPressed,
  output logic       upArrowPressed,
  output logic       firePressed,
  output logic       firePulse
);

  logic [2:0]          keyId;
  logic                keyMake;
  logic                keyBrk;
  logic [NUM_KEYS-1:0] rawKeys;
  logic [NUM_KEYS-1:0] setMask;
  logic [NUM_KEYS-1:0] clrMask;

  scan_prefix_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uPrefix (
    .clk           (clk),
    .resetN        (resetN),
    .din           (din),
    .din_new       (din_new),
    .key_id        (keyId),
    .key_make      (keyMake),
    .key_brk_strobe(keyBrk)
  );

  always_comb begin
    setMask = '0;
    clrMask = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      setMask[i] = keyMake && (keyId == 3'(i));
      clrMask[i] = keyBrk  && (keyId == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      rawKeys           <= '0;
      leftArrowPressed  <= 1'b0;
      rightArrowPressed <= 1'b0;
      downArrowPressed  <= 1'b0;
      upArrowPressed    <= 1'b0;
      firePressed       <= 1'b0;
      firePulse         <= 1'b0;
    end else begin
      rawKeys <= (rawKeys | setMask) & ~clrMask;
      // The latch reads rawKeys before this clock's update, so a byte landing
      // on the startOfFrame clock only shows up at the following frame.
      if (startOfFrame) begin
        leftArrowPressed  <= rawKeys[KEY_LEFT];
        rightArrowPressed <= rawKeys[KEY_RIGHT];
        downArrowPressed  <= rawKeys[KEY_DOWN];
        upArrowPressed    <= rawKeys[KEY_UP];
        firePressed       <= rawKeys[KEY_FIRE];
        firePulse         <= rawKeys[KEY_FIRE] & ~firePressed;
      end else begin
        firePulse <= 1'b0;
      end
    end
  end

endmodule
